// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard controller and its mult/div timer.
package hazard_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  localparam int REG_W      = 5;
  localparam int MD_LAT_DEF = 4;

endpackage

// File: rtl/muldiv_timer.sv
// HI/LO occupancy tracker: the counter loads MD_LAT on a launch and counts down to idle.
module muldiv_timer
  import hazard_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEF,
  parameter int CNT_W  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic md_start,
  output logic md_busy
);

  localparam logic [CNT_W-1:0] LAT_V = CNT_W'(MD_LAT);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             md_busy_q, md_busy_d;

  // A launch is never seen while BUSY because the hazard logic blocks it, so
  // BUSY only ever counts down.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (md_start) begin
          cnt_d   = LAT_V;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        if (cnt_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    md_busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      md_busy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      md_busy_q <= md_busy_d;
    end
  end

  assign md_busy = md_busy_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler beside ID: load-use, branch flush and mult/div arbitration.
// Define HAZ_PERF_EN to add the stall and flush performance counters.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEF,
  parameter int CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_ex_memread,
  input  logic [REG_W-1:0] id_ex_rt,
  input  logic [REG_W-1:0] if_id_rs,
  input  logic [REG_W-1:0] if_id_rt,
  input  logic             jump,
  input  logic             beq,
  input  logic             bne,
  input  logic             is_equal,
  input  logic             id_muldiv,
  input  logic             id_hilo_rd,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             if_flush,
  output logic             md_start,
  output logic             md_busy
`ifdef HAZ_PERF_EN
  ,
  output logic [31:0]      perf_stall_cnt,
  output logic [31:0]      perf_flush_cnt
`endif
);

  logic load_stall;
  logic md_stall;
  logic stall;
  logic branch_taken;

  assign load_stall   = id_ex_memread && (id_ex_rt != '0) &&
                        ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));
  assign md_stall     = md_busy && (id_muldiv || id_hilo_rd);
  assign stall        = load_stall || md_stall;
  assign branch_taken = jump || (beq && is_equal) || (bne && !is_equal);

  // A stalled branch stays unresolved, and a stalled mult/div does not launch.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_flush     = 1'b0;
    md_start     = 1'b0;
    if (stall) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else begin
      if_flush = branch_taken;
      md_start = id_muldiv;
    end
  end

  muldiv_timer #(
    .MD_LAT (MD_LAT),
    .CNT_W  (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .md_start (md_start),
    .md_busy  (md_busy)
  );

`ifdef HAZ_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q + (stall    ? 32'd1 : 32'd0);
    perf_flush_d = perf_flush_q + (if_flush ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table, corner sequences and random traffic.
module tb_pipeline_hazard_ctrl;

  localparam int LAT = 4;
  localparam int CW  = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_ex_memread;
  logic [4:0] id_ex_rt, if_id_rs, if_id_rt;
  logic       jump, beq, bne, is_equal, id_muldiv, id_hilo_rd;
  logic       pc_write, if_id_write, id_ex_bubble, if_flush, md_start, md_busy;
`ifdef HAZ_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .MD_LAT (LAT),
    .CNT_W  (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_ex_memread (id_ex_memread),
    .id_ex_rt      (id_ex_rt),
    .if_id_rs      (if_id_rs),
    .if_id_rt      (if_id_rt),
    .jump          (jump),
    .beq           (beq),
    .bne           (bne),
    .is_equal      (is_equal),
    .id_muldiv     (id_muldiv),
    .id_hilo_rd    (id_hilo_rd),
    .pc_write      (pc_write),
    .if_id_write   (if_id_write),
    .id_ex_bubble  (id_ex_bubble),
    .if_flush      (if_flush),
    .md_start      (md_start),
    .md_busy       (md_busy)
`ifdef HAZ_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  typedef struct {
    logic       memread;
    logic [4:0] ex_rt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       jump;
    logic       beq;
    logic       bne;
    logic       eq;
    logic       muldiv;
    logic       hilo;
  } stim_t;

  // exp = {pc_write, if_id_write, id_ex_bubble, if_flush, md_start}
  typedef struct {
    stim_t      s;
    logic [4:0] exp;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model: the unit is busy in every cycle number up to busy_end.
  int          cyc = 0;
  int          busy_end = -1;
  logic [31:0] m_stall_cnt = '0;
  logic [31:0] m_flush_cnt = '0;
  logic        m_stall, m_flush, m_start;

  logic [4:0]  obs_ctl;
  logic        obs_busy;

  function automatic stim_t mk(input logic memread, input int ex_rt, input int rs, input int rt,
                               input logic jmp, input logic bq, input logic bn, input logic eq,
                               input logic muldiv, input logic hilo);
    stim_t s;
    s.memread = memread;
    s.ex_rt   = 5'(ex_rt);
    s.rs      = 5'(rs);
    s.rt      = 5'(rt);
    s.jump    = jmp;
    s.beq     = bq;
    s.bne     = bn;
    s.eq      = eq;
    s.muldiv  = muldiv;
    s.hilo    = hilo;
    return s;
  endfunction

  task automatic check1(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input stim_t s);
    logic busy, load, mds, br;
    busy    = (cyc <= busy_end);
    load    = s.memread && (s.ex_rt != 5'd0) && ((s.ex_rt == s.rs) || (s.ex_rt == s.rt));
    mds     = busy && (s.muldiv || s.hilo);
    m_stall = load || mds;
    br      = s.jump || (s.beq && s.eq) || (s.bne && !s.eq);
    m_flush = !m_stall && br;
    m_start = s.muldiv && !m_stall;
    obs_ctl  = {pc_write, if_id_write, id_ex_bubble, if_flush, md_start};
    obs_busy = md_busy;
    check1({tag, ".ctl"}, 32'(obs_ctl), 32'({!m_stall, !m_stall, m_stall, m_flush, m_start}));
    check1({tag, ".busy"}, 32'(md_busy), 32'(busy));
`ifdef HAZ_PERF_EN
    check1({tag, ".perf_stall"}, perf_stall_cnt, m_stall_cnt);
    check1({tag, ".perf_flush"}, perf_flush_cnt, m_flush_cnt);
`endif
  endtask

  task automatic applyStimulus(input string tag, input stim_t s, input logic rst_v);
    rst_n         = rst_v;
    id_ex_memread = s.memread;
    id_ex_rt      = s.ex_rt;
    if_id_rs      = s.rs;
    if_id_rt      = s.rt;
    jump          = s.jump;
    beq           = s.beq;
    bne           = s.bne;
    is_equal      = s.eq;
    id_muldiv     = s.muldiv;
    id_hilo_rd    = s.hilo;
    #3;
    checkOutput(tag, s);
    @(posedge clk);
    if (!rst_v) begin
      busy_end    = cyc;
      m_stall_cnt = '0;
      m_flush_cnt = '0;
    end else begin
      if (m_start) busy_end = cyc + LAT;
      if (m_stall) m_stall_cnt = m_stall_cnt + 32'd1;
      if (m_flush) m_flush_cnt = m_flush_cnt + 32'd1;
    end
    cyc++;
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t  tbl[$];
    vec_t  v;
    stim_t z, mult, mflo, rs;
    int    n, t0, t1, tcur;

    z    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mult = mk(0, 0, 1, 2, 0, 0, 0, 0, 1, 0);
    mflo = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    rst_n = 1'b0;
    id_ex_memread = 0; id_ex_rt = 0; if_id_rs = 0; if_id_rt = 0;
    jump = 0; beq = 0; bne = 0; is_equal = 0; id_muldiv = 0; id_hilo_rd = 0;
    @(posedge clk);
    #1;
    applyStimulus("reset", z, 1'b0);
    check1("reset.ctl_const", 32'(obs_ctl), 32'(5'b11000));

    v.s = mk(1, 5, 5, 0, 0, 0, 0, 0, 0, 0); v.exp = 5'b00100; tbl.push_back(v);
    v.s = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); v.exp = 5'b11000; tbl.push_back(v);
    v.s = mk(1, 5, 3, 5, 0, 0, 0, 0, 0, 0); v.exp = 5'b00100; tbl.push_back(v);
    v.s = mk(1, 5, 3, 4, 0, 0, 0, 0, 0, 0); v.exp = 5'b11000; tbl.push_back(v);
    v.s = mk(0, 5, 5, 5, 0, 0, 0, 0, 0, 0); v.exp = 5'b11000; tbl.push_back(v);
    v.s = mk(0, 0, 1, 2, 0, 1, 0, 1, 0, 0); v.exp = 5'b11010; tbl.push_back(v);
    v.s = mk(0, 0, 1, 2, 0, 1, 0, 0, 0, 0); v.exp = 5'b11000; tbl.push_back(v);
    v.s = mk(0, 0, 1, 2, 0, 0, 1, 0, 0, 0); v.exp = 5'b11010; tbl.push_back(v);
    v.s = mk(0, 0, 1, 2, 0, 0, 1, 1, 0, 0); v.exp = 5'b11000; tbl.push_back(v);
    v.s = mk(0, 0, 1, 2, 1, 0, 0, 0, 0, 0); v.exp = 5'b11010; tbl.push_back(v);
    v.s = mk(1, 9, 9, 1, 0, 1, 0, 1, 0, 0); v.exp = 5'b00100; tbl.push_back(v);
    v.s = mk(0, 0, 1, 2, 0, 0, 0, 0, 1, 0); v.exp = 5'b11001; tbl.push_back(v);
    v.s = mk(1, 2, 1, 2, 0, 0, 0, 0, 1, 0); v.exp = 5'b00100; tbl.push_back(v);
    v.s = mk(0, 0, 1, 2, 0, 0, 0, 0, 0, 1); v.exp = 5'b11000; tbl.push_back(v);

    foreach (tbl[i]) begin
      applyStimulus("vec", tbl[i].s, 1'b1);
      check1($sformatf("vec%0d.table", i), 32'(obs_ctl), 32'(tbl[i].exp));
      applyStimulus("vec_rst", z, 1'b0);
    end

    // Load-use stall lasts one cycle once the load leaves EX.
    applyStimulus("ldu", mk(1, 5, 5, 0, 0, 0, 0, 0, 0, 0), 1'b1);
    check1("ldu.stall", 32'(!obs_ctl[4]), 32'd1);
    applyStimulus("ldu_next", mk(0, 5, 5, 0, 0, 0, 0, 0, 0, 0), 1'b1);
    check1("ldu_next.stall", 32'(!obs_ctl[4]), 32'd0);

    // Branch held by a load-use stall resolves one cycle later.
    applyStimulus("br_stall", mk(1, 7, 7, 0, 0, 1, 0, 1, 0, 0), 1'b1);
    check1("br_stall.flush", 32'(obs_ctl[1]), 32'd0);
    applyStimulus("br_go", mk(0, 7, 7, 0, 0, 1, 0, 1, 0, 0), 1'b1);
    check1("br_go.flush", 32'(obs_ctl[1]), 32'd1);

    // MULT then dependent MFLO: stall length must equal the latency.
    applyStimulus("rst", z, 1'b0);
    applyStimulus("mult", mult, 1'b1);
    check1("mult.start", 32'(obs_ctl[0]), 32'd1);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus("mflo", mflo, 1'b1);
      if (obs_ctl[4]) break;
      n++;
    end
    check1("mflo.stall_len", 32'(n), 32'(LAT));

    // Back-to-back MULTs: launches LAT+1 cycles apart.
    applyStimulus("rst", z, 1'b0);
    t0 = cyc;
    applyStimulus("mult_a", mult, 1'b1);
    t1 = -1;
    for (int k = 0; k < 20; k++) begin
      tcur = cyc;
      applyStimulus("mult_b", mult, 1'b1);
      if (obs_ctl[0]) begin
        t1 = tcur;
        break;
      end
    end
    check1("b2b.gap", 32'(t1 - t0), 32'(LAT + 1));

    // Reset in the middle of a busy period releases a waiting MFLO.
    applyStimulus("rst", z, 1'b0);
    applyStimulus("rb_mult", mult, 1'b1);
    applyStimulus("rb_mflo", mflo, 1'b1);
    check1("rb_mflo.stall", 32'(!obs_ctl[4]), 32'd1);
    applyStimulus("rb_reset", mflo, 1'b0);
    applyStimulus("rb_after", mflo, 1'b1);
    check1("rb_after.busy", 32'(obs_busy), 32'd0);
    check1("rb_after.stall", 32'(!obs_ctl[4]), 32'd0);

    // Random traffic with small register numbers for frequent matches.
    for (int i = 0; i < 400; i++) begin
      rs.memread = ($urandom_range(0, 2) == 0);
      rs.ex_rt   = 5'($urandom_range(0, 3));
      rs.rs      = 5'($urandom_range(0, 3));
      rs.rt      = 5'($urandom_range(0, 3));
      rs.jump    = ($urandom_range(0, 7) == 0);
      rs.beq     = ($urandom_range(0, 3) == 0);
      rs.bne     = ($urandom_range(0, 3) == 0);
      rs.eq      = 1'($urandom_range(0, 1));
      rs.muldiv  = ($urandom_range(0, 3) == 0);
      rs.hilo    = ($urandom_range(0, 3) == 0);
      applyStimulus("rnd", rs, ($urandom_range(0, 39) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush scheduler for the 5-stage MIPS pipeline, sitting beside the ID stage. Combines load-use hazard detection, ID-stage branch/jump flush, and arbitration of the shared multi-cycle multiply/divide unit into one set of pipeline-register enables. It tracks HI/LO occupancy with a down-counter and stalls any instruction in ID that needs the unit or its result while the unit is busy.

## Interface
- `MD_LAT`, 4: mult/div latency in cycles, legal range 1..15.
- `CNT_W`, 4: width of the busy counter; must satisfy 2^CNT_W > MD_LAT.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, synchronous and active-low; one clock.
- `id_ex_memread`  in  1  instruction in EX is a load.
- `id_ex_rt`  in  5  load destination register.
- `if_id_rs`, `if_id_rt`  in  5 each  source registers of the instruction in ID.
- `jump`, `beq`, `bne`, `is_equal`  in  1 each  ID-stage control and comparator result.
- `id_muldiv`  in  1  instruction in ID is MULT/MULTU/DIV/DIVU.
- `id_hilo_rd`  in  1  instruction in ID is MFHI/MFLO.
- `pc_write`  out  1  1 = PC advances.
- `if_id_write`  out  1  1 = IF/ID register loads.
- `id_ex_bubble`  out  1  1 = zero control fields into ID/EX.
- `if_flush`  out  1  1 = squash the instruction entering IF/ID.
- `md_start`  out  1  launch pulse to the mult/div unit.
- `md_busy`  out  1  unit occupied.

## Operation
- `load_stall` = `id_ex_memread` & (`id_ex_rt` != 0) & (`id_ex_rt` == `if_id_rs` | `id_ex_rt` == `if_id_rt`).
- `md_stall` = `md_busy` & (`id_muldiv` | `id_hilo_rd`). This is a structural or HI/LO hazard.
- `stall` = `load_stall` | `md_stall`.
- Outputs while `stall` = 1:
  - `pc_write` = 0, `if_id_write` = 0, `id_ex_bubble` = 1.
  - `if_flush` = 0. A branch in ID is not resolved while it is stalled.
  - `md_start` = 0.
- `if_flush` = !`stall` & (`jump` | (`beq` & `is_equal`) | (`bne` & !`is_equal`)).
- `md_start` = `id_muldiv` & !`stall`.
- FSM states:
  - IDLE (`cnt` == 0) -> BUSY on `md_start`.
  - BUSY -> IDLE when `cnt` reaches 0.
  - BUSY -> BUSY, with `cnt` reloaded, never happens: `md_stall` blocks a start while busy.
- Counter `cnt` is CNT_W bits wide.
  - It loads MD_LAT at the edge ending the `md_start` cycle.
  - It then decrements by 1 per cycle and saturates at 0.
  - `md_busy` = (`cnt` != 0).
- Reset values: `cnt` = 0, state IDLE, `md_busy` = 0.
- Outputs are combinational from the inputs and `cnt`. With all inputs 0 during reset: `pc_write` = 1, `if_id_write` = 1, `id_ex_bubble` = 0, `if_flush` = 0, `md_start` = 0.
- Reset asserted while BUSY clears `cnt` at that edge. The unit is abandoned and no further stall is produced.

## Timing
- Load-use stall: asserted in the same cycle as detection. It lasts exactly 1 cycle, because the load leaves EX at the next edge.
- Mult/div in ID at cycle T with no stall:
  - `md_start` = 1 in cycle T.
  - `md_busy` = 1 in cycles T+1 .. T+MD_LAT.
  - HI/LO is readable from cycle T+MD_LAT+1.
- A dependent MFHI/MFLO in ID at T+1 stalls for exactly MD_LAT cycles.
- Simultaneous `load_stall` and `md_stall` produce one merged stall. The stall lasts until both conditions clear.
- Flush latency: 0 cycles, same cycle as branch resolution.

## Configuration
- `HAZ_PERF_EN` defined adds two outputs:
  - `perf_stall_cnt` [31:0]: increments on every cycle with `stall` = 1.
  - `perf_flush_cnt` [31:0]: increments on every cycle with `if_flush` = 1.
  - Both clear on `rst_n` = 0 and wrap modulo 2^32.
- `HAZ_PERF_EN` undefined: the ports and counters do not exist and the remaining behaviour is identical.

## Structure
- Shared package `hazard_pkg` holds:
  - the state enum {IDLE, BUSY};
  - `REG_W` = 5;
  - the default `MD_LAT`.
- One sub-module, `muldiv_timer`. It contains the `cnt` register, the load/decrement logic and `md_busy`.
- The top level holds only the hazard equations and the output mux.

## Test plan
- Load `id_ex_rt` = 5 with `if_id_rs` = 5 -> one cycle of `pc_write` = 0, `if_id_write` = 0, `id_ex_bubble` = 1, then normal flow.
- Load `id_ex_rt` = 0 with `if_id_rs` = 0 -> no stall.
- `beq` with `is_equal` = 1 -> `if_flush` = 1 for one cycle. The same case with a concurrent load-use stall -> `if_flush` = 0 during the stall, then 1 in the following cycle.
- MD_LAT = 4: MULT at T, then MFLO at T+1 -> `md_busy` high T+1..T+4, stall T+1..T+4, MFLO proceeds at T+5.
- Two back-to-back MULTs -> the second stalls 4 cycles, and `md_start` pulses at T and T+5.
- `rst_n` = 0 at T+2 of a busy period -> `md_busy` = 0 from T+3, and a pending MFLO proceeds. With `HAZ_PERF_EN`, counters read 0 after reset and match the number of stall/flush cycles observed.
